mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, giving the RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, giving the data width, which must be a multiple of 8.
REQ-003 SHALL have port clk, input, 1: the only clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports m0_req/m1_req, input, 1: access request from CPU data port (m0) and UART loader (m1).
REQ-006 SHALL have ports m0_we/m1_we, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have ports m0_addr/m1_addr, input, ADDR_W: word address.
REQ-008 SHALL have ports m0_wdata/m1_wdata, input, DATA_W: write data.
REQ-009 SHALL have ports m0_be/m1_be, input, DATA_W/8: byte enables.
REQ-010 SHALL have ports m0_gnt/m1_gnt, output, 1: request accepted; fields already captured.
REQ-011 SHALL have ports m0_done/m1_done, output, 1: access complete.
REQ-012 SHALL have ports m0_rdata/m1_rdata, output, DATA_W: read data, valid while the matching done is 1.
REQ-013 SHALL have ports ram_en (output, 1), ram_we (output, DATA_W/8), ram_addr (output, ADDR_W), ram_wdata (output, DATA_W) and ram_rdata (input, DATA_W), driving a single-port RAM with 1-cycle read latency.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-015 SHALL arbitrate in IDLE and in DONE. If any req is 1, it SHALL latch the winner's we/addr/wdata/be and move to BUSY on the next edge; otherwise it SHALL move to IDLE.
REQ-016 SHALL use round-robin arbitration when both requests are 1: the port not granted last wins. With one request, that port SHALL win.
REQ-017 SHALL, in BUSY, assert ram_en=1, drive the latched addr/wdata, and drive ram_we=be for writes or 0 for reads. It SHALL also assert the winner's gnt for exactly this cycle, then move to DONE.
REQ-018 SHALL, in DONE, pulse the winner's done for 1 cycle. For reads, the winner's rdata SHALL equal ram_rdata in that cycle; the loser's rdata SHALL be 0.
REQ-019 SHALL give a latency of 2 cycles from the req-sampled edge to done. Back-to-back throughput SHALL be one access per 2 cycles.
REQ-020 SHALL treat a request dropped before its gnt as discarded, with no RAM access. A requester SHALL hold its fields stable until gnt.
REQ-021 SHALL ignore requests raised in BUSY until the next arbitration cycle. m0_gnt and m1_gnt SHALL never both be 1.
REQ-022 SHALL hold ram_en=0 and ram_we=0 whenever the state is not BUSY.

Reset
REQ-023 SHALL, on a reset edge, set state=IDLE, set all gnt/done/rdata/ram_* outputs to 0, and set last-granted to m1, so m0 wins the first tie.
REQ-024 SHALL, on reset in BUSY or DONE, abort the access: no done pulse, and ram_en low from the next cycle.

Configuration
REQ-025 SHALL, when macro MEM_ARBITER_FIXED_PRIO_EN is defined, always give m0 priority on ties, with no last-granted state.
REQ-026 SHALL, when MEM_ARBITER_FIXED_PRIO_EN is undefined, use the round-robin rule of REQ-016. All other behaviour SHALL be identical in both builds.

Structure
REQ-027 SHALL place the state encoding (IDLE/BUSY/DONE) and the port index constants (PORT_M0=0, PORT_M1=1) in shared package mem_arbiter_pkg.
REQ-028 SHALL place the 2-input winner selection (req[1:0], last -> win) in sub-module rr_arb2, combinational, with the fixed-priority variant selected by the macro.

Verification
REQ-029 SHALL cover single read: m0 read addr 0x010 with RAM[0x010]=0x12345678 -> m0_gnt in cycle 1, m0_done in cycle 2, m0_rdata=0x12345678.
REQ-030 SHALL cover byte write: m1 write addr 0x020, wdata 0xAABBCCDD, be 4'b0011 -> ram_we=4'b0011 for 1 cycle; a later read of 0x020 returns 0x????CCDD with the old upper bytes kept.
REQ-031 SHALL cover continuous contention: both req held for 8 accesses from reset -> grant order m0,m1,m0,m1,... With MEM_ARBITER_FIXED_PRIO_EN it SHALL be m0 ×8 and m1 none.
REQ-032 SHALL cover withdrawal: m1_req high for 1 cycle while BUSY serves m0, then low -> no m1_gnt and no RAM access with m1 fields.
REQ-033 SHALL cover mid-operation reset: reset asserted in BUSY of an m0 write -> no m0_done, all outputs 0 on the next cycle, FSM IDLE; after release, m0 wins the first tie.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared state encoding and port indices for the two-master RAM arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic PORT_M0 = 1'b0;
    localparam logic PORT_M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input winner select: round-robin on ties, or m0-first when
// MEM_ARBITER_FIXED_PRIO_EN is defined (no last-granted input then).
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
`ifndef MEM_ARBITER_FIXED_PRIO_EN
    input  logic       last,
`endif
    output logic       win
);

`ifdef MEM_ARBITER_FIXED_PRIO_EN
    assign win = (req[1] && !req[0]) ? PORT_M1 : PORT_M0;
`else
    // m1 wins alone, or on a tie when m0 was served last
    assign win = (req[1] && (!req[0] || last == PORT_M0))
               ? PORT_M1 : PORT_M0;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-master single-port RAM arbiter, one access per two cycles.
// Define MEM_ARBITER_FIXED_PRIO_EN for fixed m0 priority on ties.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_be,
    output logic                m0_gnt,
    output logic                m0_done,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_be,
    output logic                m1_gnt,
    output logic                m1_done,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                ram_en,
    output logic [DATA_W/8-1:0] ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    localparam int BE_W = DATA_W / 8;

    state_t state;
    logic   win;
    logic   cur;
    logic   we_l;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [BE_W-1:0]   sel_be;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
    rr_arb2 u_arb (
        .req ({m1_req, m0_req}),
        .win (win)
    );
`else
    logic last;

    rr_arb2 u_arb (
        .req  ({m1_req, m0_req}),
        .last (last),
        .win  (win)
    );
`endif

    assign sel_we    = (win == PORT_M1) ? m1_we    : m0_we;
    assign sel_addr  = (win == PORT_M1) ? m1_addr  : m0_addr;
    assign sel_wdata = (win == PORT_M1) ? m1_wdata : m0_wdata;
    assign sel_be    = (win == PORT_M1) ? m1_be    : m0_be;

    // RAM data lands in the DONE cycle, so read data is steered, not stored
    assign m0_rdata = (m0_done && !we_l) ? ram_rdata : '0;
    assign m1_rdata = (m1_done && !we_l) ? ram_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur       <= PORT_M0;
            we_l      <= 1'b0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_done   <= 1'b0;
            m1_done   <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
            last      <= PORT_M1;
`endif
        end else if (state == BUSY) begin
            state   <= DONE;
            m0_gnt  <= 1'b0;
            m1_gnt  <= 1'b0;
            ram_en  <= 1'b0;
            ram_we  <= '0;
            m0_done <= (cur == PORT_M0);
            m1_done <= (cur == PORT_M1);
        end else begin
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            if (m0_req || m1_req) begin
                state     <= BUSY;
                cur       <= win;
                we_l      <= sel_we;
                m0_gnt    <= (win == PORT_M0);
                m1_gnt    <= (win == PORT_M1);
                ram_en    <= 1'b1;
                ram_we    <= sel_we ? sel_be : '0;
                ram_addr  <= sel_addr;
                ram_wdata <= sel_wdata;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
                last      <= win;
`endif
            end else begin
                state  <= IDLE;
                m0_gnt <= 1'b0;
                m1_gnt <= 1'b0;
                ram_en <= 1'b0;
                ram_we <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction model.
module tb_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [1:0]    rq = '0;
    logic [1:0]    wq = '0;
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    logic [BW-1:0] bq [2];

    logic          m0_gnt, m0_done, m1_gnt, m1_done;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          ram_en;
    logic [BW-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    logic          bd_en = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (rq[0]),
        .m0_we     (wq[0]),
        .m0_addr   (ad[0]),
        .m0_wdata  (wd[0]),
        .m0_be     (bq[0]),
        .m0_gnt    (m0_gnt),
        .m0_done   (m0_done),
        .m0_rdata  (m0_rdata),
        .m1_req    (rq[1]),
        .m1_we     (wq[1]),
        .m1_addr   (ad[1]),
        .m1_wdata  (wd[1]),
        .m1_be     (bq[1]),
        .m1_gnt    (m1_gnt),
        .m1_done   (m1_done),
        .m1_rdata  (m1_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // RAM with one-cycle read latency and a backdoor preload port
    logic [DW-1:0] ram_arr [0:4095];
    always @(posedge clk) begin
        if (bd_en) ram_arr[bd_addr] <= bd_data;
        if (ram_en) begin
            for (int b = 0; b < BW; b++)
                if (ram_we[b])
                    ram_arr[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= ram_arr[ram_addr];
        end
    end

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o,
                                            input logic [DW-1:0] n,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int b = 0; b < BW; b++)
            if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Transaction model: an accepted request occupies the next cycle,
    // completes the cycle after, and the arbiter is free otherwise.
    logic [DW-1:0] ref_mem [0:4095];
    logic          in_flight = 1'b0;
    logic          last_w = 1'b1;
    logic          cw = 1'b0;
    logic          cwe = 1'b0;
    logic [AW-1:0] caddr = '0;
    logic [DW-1:0] cwd = '0;
    logic [BW-1:0] cbe = '0;
    logic [1:0]    e_gnt = '0;
    logic [1:0]    e_done = '0;
    logic          e_en = 1'b0;
    logic [BW-1:0] e_we = '0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wd = '0;
    logic [DW-1:0] e_rd = '0;
    logic          e_rdv = 1'b0;

    always @(posedge clk) begin
        if (bd_en) ref_mem[bd_addr] = bd_data;
        e_rd = ref_mem[caddr];
        // the RAM sees an issued access on this edge even if reset aborts it
        if (in_flight && cwe)
            ref_mem[caddr] = merge(ref_mem[caddr], cwd, cbe);
        if (reset) begin
            in_flight = 1'b0;
            last_w = 1'b1;
            e_gnt = '0;
            e_done = '0;
            e_en = 1'b0;
            e_we = '0;
            e_rdv = 1'b0;
        end else if (in_flight) begin
            in_flight = 1'b0;
            e_gnt = '0;
            e_en = 1'b0;
            e_we = '0;
            e_done = '0;
            e_done[cw] = 1'b1;
            e_rdv = !cwe;
        end else begin
            e_done = '0;
            e_rdv = 1'b0;
            if (rq != 2'b00) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
                cw = (rq == 2'b10);
`else
                cw = (rq == 2'b11) ? !last_w : rq[1];
`endif
                cwe = wq[cw];
                caddr = ad[cw];
                cwd = wd[cw];
                cbe = bq[cw];
                last_w = cw;
                in_flight = 1'b1;
                e_gnt = '0;
                e_gnt[cw] = 1'b1;
                e_en = 1'b1;
                e_we = cwe ? cbe : '0;
                e_addr = caddr;
                e_wd = cwd;
            end else begin
                e_gnt = '0;
                e_en = 1'b0;
                e_we = '0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        chk("gnt0", m0_gnt, e_gnt[0]);
        chk("gnt1", m1_gnt, e_gnt[1]);
        chk("done0", m0_done, e_done[0]);
        chk("done1", m1_done, e_done[1]);
        chk("ram_en", ram_en, e_en);
        chk("ram_we", ram_we, e_we);
        chk("gnt_excl", m0_gnt & m1_gnt, 0);
        if (e_en) begin
            chk("ram_addr", ram_addr, e_addr);
            chk("ram_wdata", ram_wdata, e_wd);
        end
        if (e_done[0]) begin
            if (e_rdv) chk("rdata0", m0_rdata, e_rd);
            chk("rdata1_lose", m1_rdata, 0);
        end
        if (e_done[1]) begin
            if (e_rdv) chk("rdata1", m1_rdata, e_rd);
            chk("rdata0_lose", m0_rdata, 0);
        end
    endtask

    task automatic newreq(input int p);
        rq[p] = 1'b1;
        wq[p] = 1'($urandom_range(0, 1));
        ad[p] = AW'($urandom_range(0, 63));
        wd[p] = $urandom;
        bq[p] = BW'($urandom_range(0, 15));
    endtask

    task automatic agent(input int p);
        logic g;
        g = (p == 0) ? m0_gnt : m1_gnt;
        if (rq[p] && g) begin
            rq[p] = 1'b0;
            if ($urandom_range(0, 3) == 0) newreq(p);
        end else if (rq[p]) begin
            if ($urandom_range(0, 15) == 0) rq[p] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
            newreq(p);
        end
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            ad[p] = '0;
            wd[p] = '0;
            bq[p] = '0;
        end

        reset = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bd_en = 1'b1;
            bd_addr = AW'(i);
            bd_data = (i == 16) ? 32'h1234_5678 :
                      (i == 32) ? 32'h1122_3344 : $urandom;
            cyc();
        end
        bd_en = 1'b0;
        cyc();
        chk("rst_en", ram_en, 0);
        chk("rst_gnt", {m1_gnt, m0_gnt}, 0);
        chk("rst_done", {m1_done, m0_done}, 0);

        // single read
        reset = 1'b0;
        rq[0] = 1'b1; wq[0] = 1'b0; ad[0] = 12'h010;
        cyc();
        chk("rd_gnt", m0_gnt, 1);
        rq[0] = 1'b0;
        cyc();
        chk("rd_done", m0_done, 1);
        chk("rd_data", m0_rdata, 32'h1234_5678);

        // byte write then read back
        rq[1] = 1'b1; wq[1] = 1'b1; ad[1] = 12'h020;
        wd[1] = 32'hAABB_CCDD; bq[1] = 4'b0011;
        cyc();
        chk("bw_gnt", m1_gnt, 1);
        chk("bw_we", ram_we, 4'b0011);
        rq[1] = 1'b0;
        cyc();
        chk("bw_done", m1_done, 1);
        chk("bw_we_off", ram_we, 0);
        rq[0] = 1'b1; wq[0] = 1'b0; ad[0] = 12'h020;
        cyc();
        rq[0] = 1'b0;
        cyc();
        chk("bw_rdback", m0_rdata, 32'h1122_CCDD);

        // continuous contention from reset
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        rq = 2'b11; wq = 2'b00; ad[0] = 12'h001; ad[1] = 12'h002;
        for (int k = 0; k < 8; k++) begin
            cyc();
`ifdef MEM_ARBITER_FIXED_PRIO_EN
            chk("rr_m0", m0_gnt, 1);
            chk("rr_m1", m1_gnt, 0);
`else
            chk("rr_m0", m0_gnt, (k % 2) == 0);
            chk("rr_m1", m1_gnt, (k % 2) == 1);
`endif
            if (k == 7) rq = 2'b00;
            cyc();
        end

        // m1 request withdrawn while m0 is being served
        cyc();
        rq[0] = 1'b1; wq[0] = 1'b0; ad[0] = 12'h001;
        cyc();
        chk("wd_gnt0", m0_gnt, 1);
        rq[0] = 1'b0;
        rq[1] = 1'b1; wq[1] = 1'b1; ad[1] = 12'h03F;
        wd[1] = 32'hDEAD_BEEF; bq[1] = 4'hF;
        cyc();
        rq[1] = 1'b0;
        chk("wd_gnt1_a", m1_gnt, 0);
        cyc();
        chk("wd_gnt1_b", m1_gnt, 0);
        chk("wd_en", ram_en, 0);

        // reset in the busy cycle of an m0 write
        rq[0] = 1'b1; wq[0] = 1'b1; ad[0] = 12'h005;
        wd[0] = $urandom; bq[0] = 4'hF;
        cyc();
        chk("mr_gnt", m0_gnt, 1);
        reset = 1'b1;
        rq[0] = 1'b0;
        cyc();
        chk("mr_done", m0_done, 0);
        chk("mr_en", ram_en, 0);
        chk("mr_gnt0", m0_gnt, 0);
        reset = 1'b0;
        rq = 2'b11; wq = 2'b00;
        cyc();
        chk("mr_tie", m0_gnt, 1);
        rq = 2'b00;
        cyc();

        // randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            cyc();
            agent(0);
            agent(1);
            reset = ($urandom_range(0, 99) == 0);
        end
        rq = 2'b00;
        reset = 1'b0;
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
